// File: rtl/pry2bin_serial.sv
// pry2bin_serial
// Purpose: takes in a priority request vector and sends out its set bits one
// beat at a time, in priority order. Each beat carries the binary index, the
// one-hot bit and a last flag. A bit is cleared once it has been sent.
// DIRECTION selects which end of the vector has priority. IMPLEMENTATION
// selects the internal priority-to-one-hot structure. All structures give the
// same result.
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          synchronous active-high reset
//   s_vld  in   1          input vector valid
//   s_rdy  out  1          input vector ready (comb. from m_rdy while busy)
//   s_pry  in   WIDTH      input priority request vector
//   m_vld  out  1          output beat valid
//   m_rdy  in   1          output beat ready
//   m_oht  out  WIDTH      one-hot of the selected bit (0 when m_vld=0)
//   m_bin  out  WIDTH_LOG  binary index of the selected bit (0 when m_vld=0)
//   m_lst  out  1          last beat of the current vector (0 when m_vld=0)
module pry2bin_serial #(
    parameter int WIDTH          = 32,
    parameter     DIRECTION      = "LSB",
    parameter int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [WIDTH-1:0]     s_pry,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [WIDTH-1:0]     m_oht,
    output logic [WIDTH_LOG-1:0] m_bin,
    output logic                 m_lst
);

    localparam bit MSB_FIRST = (DIRECTION == "MSB");

    // Reject parameter combinations that have no defined behaviour.
    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "pry2bin_serial: WIDTH must be >= 2");
    end
    if ((DIRECTION != "LSB") && (DIRECTION != "MSB")) begin : g_bad_dir
        $fatal(1, "pry2bin_serial: DIRECTION must be \"LSB\" or \"MSB\"");
    end
    if ((IMPLEMENTATION < 0) || (IMPLEMENTATION > 2)) begin : g_bad_impl
        $fatal(1, "pry2bin_serial: IMPLEMENTATION must be 0, 1 or 2");
    end
    if ((IMPLEMENTATION == 2) && MSB_FIRST) begin : g_bad_adder
        $fatal(1, "pry2bin_serial: IMPLEMENTATION 2 supports DIRECTION \"LSB\" only");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sta_t;

    sta_t                 sta_q, sta_d;
    logic [WIDTH-1:0]     rem_q, rem_d;

    logic [WIDTH-1:0]     pri_in_s;   // rem_q oriented so that bit 0 has priority
    logic [WIDTH-1:0]     lsb_oht_s;  // lowest set bit of pri_in_s
    logic [WIDTH-1:0]     oht_raw_s;  // selected bit in the original orientation
    logic [WIDTH_LOG-1:0] bin_raw_s;
    logic [WIDTH-1:0]     rem_clr_s;
    logic                 lst_raw_s;
    logic                 busy_s;

    // Put rem into LSB-priority orientation. MSB priority is handled by
    // reversing the vector, so each structure only needs to find the lowest set bit.
    always_comb begin
        pri_in_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                pri_in_s[i] = rem_q[WIDTH-1-i];
            end else begin
                pri_in_s[i] = rem_q[i];
            end
        end
    end

    if (IMPLEMENTATION == 0) begin : g_loop
        // Priority select as a linear scan that stops at the first set bit.
        always_comb begin
            logic found;
            found     = 1'b0;
            lsb_oht_s = {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                if (pri_in_s[i] && !found) begin
                    lsb_oht_s[i] = 1'b1;
                    found        = 1'b1;
                end else begin
                    lsb_oht_s[i] = 1'b0;
                end
            end
        end
    end else if (IMPLEMENTATION == 1) begin : g_vector
        // Priority select with a log-depth smear. smear[i] is set when any bit
        // at or below i is set, so a bit wins when nothing below it is set.
        always_comb begin
            logic [WIDTH-1:0] smear;
            smear = pri_in_s;
            for (int s = 1; s < WIDTH; s = s * 2) begin
                smear = smear | (smear << s);
            end
            lsb_oht_s = pri_in_s & ~(smear << 1);
        end
    end else begin : g_adder
        // Priority select with two's complement: x & -x isolates the lowest set bit.
        always_comb begin
            lsb_oht_s = pri_in_s & (~pri_in_s + {{(WIDTH-1){1'b0}}, 1'b1});
        end
    end

    // Turn the selected bit back to the original orientation and encode it.
    always_comb begin
        oht_raw_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                oht_raw_s[i] = lsb_oht_s[WIDTH-1-i];
            end else begin
                oht_raw_s[i] = lsb_oht_s[i];
            end
        end
        bin_raw_s = {WIDTH_LOG{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (oht_raw_s[i]) begin
                bin_raw_s = bin_raw_s | WIDTH_LOG'(i);
            end else begin
                bin_raw_s = bin_raw_s;
            end
        end
        rem_clr_s = rem_q & ~oht_raw_s;
        lst_raw_s = (rem_clr_s == {WIDTH{1'b0}});
    end

    // Handshake and beat outputs. During reset both valid/ready are forced low.
    // Beat fields are zero whenever no beat is presented.
    always_comb begin
        busy_s = (sta_q == BUSY);
        m_vld  = busy_s & ~rst;
        if (rst) begin
            s_rdy = 1'b0;
        end else if (busy_s) begin
            // A new vector can only be taken while the last beat leaves.
            s_rdy = m_rdy & lst_raw_s;
        end else begin
            s_rdy = 1'b1;
        end
        if (m_vld) begin
            m_oht = oht_raw_s;
            m_bin = bin_raw_s;
            m_lst = lst_raw_s;
        end else begin
            m_oht = {WIDTH{1'b0}};
            m_bin = {WIDTH_LOG{1'b0}};
            m_lst = 1'b0;
        end
    end

    // Next-state logic for the IDLE/BUSY controller and the remaining-bit vector.
    always_comb begin
        sta_d = sta_q;
        rem_d = rem_q;
        case (sta_q)
            IDLE: begin
                if (s_vld && s_rdy && (s_pry != {WIDTH{1'b0}})) begin
                    rem_d = s_pry;
                    sta_d = BUSY;
                end else begin
                    // An all-zero vector is consumed without producing a beat.
                    sta_d = IDLE;
                end
            end
            BUSY: begin
                if (m_rdy && !lst_raw_s) begin
                    rem_d = rem_clr_s;
                end else if (m_rdy && s_vld && s_rdy && (s_pry != {WIDTH{1'b0}})) begin
                    // Last beat leaves while the next vector arrives: no bubble.
                    rem_d = s_pry;
                    sta_d = BUSY;
                end else if (m_rdy) begin
                    rem_d = {WIDTH{1'b0}};
                    sta_d = IDLE;
                end else begin
                    // Backpressure: hold everything.
                    rem_d = rem_q;
                    sta_d = BUSY;
                end
            end
            default: begin
                rem_d = {WIDTH{1'b0}};
                sta_d = IDLE;
            end
        endcase
    end

    // State and remaining-bit registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sta_q <= IDLE;
            rem_q <= {WIDTH{1'b0}};
        end else begin
            sta_q <= sta_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: tb/tb_pry2bin_serial.sv
module tb_pry2bin_serial;

    localparam int NDUT = 5;   // 0..2: LSB impl 0/1/2, 3..4: MSB impl 0/1

    logic                  clk;
    logic                  rst;
    logic                  s_vld;
    logic [7:0]            s_pry;
    logic                  m_rdy;
    logic [NDUT-1:0]       s_rdy_v;
    logic [NDUT-1:0]       m_vld_v;
    logic [NDUT-1:0]       m_lst_v;
    logic [NDUT-1:0][7:0]  m_oht_v;
    logic [NDUT-1:0][2:0]  m_bin_v;

    int checks;
    int errors;
    bit rand_rdy;
    bit done;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam bit MSBF = (g >= 3);

        pry2bin_serial #(
            .WIDTH          (8),
            .DIRECTION      (MSBF ? "MSB" : "LSB"),
            .IMPLEMENTATION (MSBF ? g - 3 : g)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .s_vld (s_vld),
            .s_rdy (s_rdy_v[g]),
            .s_pry (s_pry),
            .m_vld (m_vld_v[g]),
            .m_rdy (m_rdy),
            .m_oht (m_oht_v[g]),
            .m_bin (m_bin_v[g]),
            .m_lst (m_lst_v[g])
        );

        int         q[$];
        int         idx[$];
        int         e;
        int         b;
        int         beats_exp;
        int         beats_seen;
        bit         stall;
        logic [7:0] hold_oht;
        logic [2:0] hold_bin;
        logic       hold_lst;

        // Scoreboard monitor: it looks at the upcoming edge from the negedge.
        // It pops a beat when a beat handshake happens. It pushes the beats the
        // reference model expects when an input vector handshake happens.
        initial begin
            beats_exp  = 0;
            beats_seen = 0;
            stall      = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    beats_exp = beats_exp - q.size();
                    q.delete();
                    stall = 1'b0;
                end else begin
                    if (stall) begin
                        chk($sformatf("hold_vld[%0d]", g), m_vld_v[g], 1);
                        chk($sformatf("hold_oht[%0d]", g), m_oht_v[g], hold_oht);
                        chk($sformatf("hold_bin[%0d]", g), m_bin_v[g], hold_bin);
                        chk($sformatf("hold_lst[%0d]", g), m_lst_v[g], hold_lst);
                    end
                    if (m_vld_v[g]) begin
                        if (m_rdy) begin
                            beats_seen++;
                            if (q.size() == 0) begin
                                chk($sformatf("extra_beat[%0d]", g), 1, 0);
                            end else begin
                                e = q.pop_front();
                                chk($sformatf("beat_bin[%0d]", g), m_bin_v[g], e & 7);
                                chk($sformatf("beat_oht[%0d]", g), m_oht_v[g], 32'd1 << (e & 7));
                                chk($sformatf("beat_lst[%0d]", g), m_lst_v[g], (e >> 3) & 1);
                            end
                        end
                        stall    = !m_rdy;
                        hold_oht = m_oht_v[g];
                        hold_bin = m_bin_v[g];
                        hold_lst = m_lst_v[g];
                    end else begin
                        chk($sformatf("idle_zero[%0d]", g), {m_oht_v[g], m_bin_v[g], m_lst_v[g]}, 0);
                        stall = 1'b0;
                    end
                    if (s_vld && s_rdy_v[g]) begin
                        // Reference model: list the set bits in priority order.
                        // The final entry carries the last flag.
                        idx.delete();
                        for (int k = 0; k < 8; k++) begin
                            b = MSBF ? 7 - k : k;
                            if (s_pry[b]) idx.push_back(b);
                        end
                        for (int k = 0; k < idx.size(); k++) begin
                            q.push_back(idx[k] | ((k == idx.size() - 1) ? 8 : 0));
                        end
                        beats_exp = beats_exp + $countones(s_pry);
                    end
                end
            end
        end

        // Final accounting: all expected beats are consumed and the beat count
        // equals the popcount total.
        initial begin
            wait (done == 1'b1);
            chk($sformatf("queue_empty[%0d]", g), q.size(), 0);
            chk($sformatf("beat_count[%0d]", g), beats_seen, beats_exp);
        end
    end

    // Random ready generator, used only while rand_rdy is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] v, input bit keep);
        bit ok;
        ok    = 1'b0;
        s_vld = 1'b1;
        s_pry = v;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_rdy_v[0]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) s_vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (m_vld_v == '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rand_rdy = 1'b0;
        done     = 1'b0;
        rst      = 1'b1;
        s_vld    = 1'b0;
        s_pry    = 8'h00;
        m_rdy    = 1'b1;

        // Reset: handshakes are low while reset is held.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_m_vld", m_vld_v, 0);
        chk("rst_s_rdy", s_rdy_v, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_rdy", s_rdy_v, 5'h1F);
        chk("post_rst_m_vld", m_vld_v, 0);
        chk("post_rst_oht", m_oht_v[0], 0);
        chk("post_rst_bin", m_bin_v[0], 0);
        chk("post_rst_lst", m_lst_v[0], 0);
        @(posedge clk);
        #1;

        // 8'hA4 with ready held: the first beat comes one cycle after accept.
        send(8'hA4, 1'b0);
        @(negedge clk);
        chk("a4_first_vld", m_vld_v, 5'h1F);
        chk("a4_lsb_bin", m_bin_v[0], 2);
        chk("a4_lsb_oht", m_oht_v[0], 8'h04);
        chk("a4_msb_bin", m_bin_v[3], 7);
        chk("a4_msb_oht", m_oht_v[3], 8'h80);
        chk("a4_first_lst", m_lst_v[0], 0);
        wait_idle();

        // 8'hA4 with backpressure during the second beat.
        send(8'hA4, 1'b0);
        @(posedge clk);
        #1;
        m_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_lsb_bin", m_bin_v[0], 5);
            chk("bp_lsb_oht", m_oht_v[0], 8'h20);
            chk("bp_msb_bin", m_bin_v[3], 5);
            chk("bp_vld", m_vld_v, 5'h1F);
            @(posedge clk);
            #1;
        end
        m_rdy = 1'b1;
        wait_idle();

        // All-zero vector: consumed, no beat.
        send(8'h00, 1'b0);
        @(negedge clk);
        chk("zero_m_vld", m_vld_v, 0);
        chk("zero_s_rdy", s_rdy_v, 5'h1F);
        @(posedge clk);
        #1;

        // Back-to-back 8'h01 then 8'h80: the second is accepted on the last beat.
        send(8'h01, 1'b1);
        s_pry = 8'h80;
        @(negedge clk);
        chk("b2b_bin0", m_bin_v[0], 0);
        chk("b2b_lst0", m_lst_v[0], 1);
        chk("b2b_s_rdy", s_rdy_v, 5'h1F);
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        @(negedge clk);
        chk("b2b_vld7", m_vld_v, 5'h1F);
        chk("b2b_bin7", m_bin_v[0], 7);
        chk("b2b_msb_bin7", m_bin_v[3], 7);
        @(posedge clk);
        #1;
        wait_idle();

        // Reset in the middle of 8'hFF, after three beats.
        send(8'hFF, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_vld", m_vld_v, 0);
        chk("mid_rst_s_rdy", s_rdy_v, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_m_vld", m_vld_v, 0);
        chk("after_rst_s_rdy", s_rdy_v, 5'h1F);
        @(posedge clk);
        #1;
        send(8'hFF, 1'b0);
        wait_idle();

        // Randomized regression with random ready.
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int mode;
            logic [7:0] v;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            mode = $urandom_range(0, 5);
            if (mode == 0)      v = 8'h00;
            else if (mode == 1) v = 8'h01 << $urandom_range(0, 7);
            else                v = 8'($urandom);
            send(v, 1'b0);
        end
        rand_rdy = 1'b0;
        m_rdy    = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
